sha2_k_sequencer: RTL and testbench
===================================

# sha2_k_sequencer

Round-constant sequencer for the SHA-2 compression datapath, the parametrised successor to the combinational SHA-256 K lookup. It holds the 80-entry, 64-bit FIPS 180-4 SHA-512 K table. SHA-256 constants are the upper 32 bits of the first 64 entries. On a start request it steps through the rounds of the selected mode and presents one registered constant per round over a valid/ready handshake. It sits between the hash control FSM and the compression round logic.

## Interface

- `MODE512_EN`, default 1: 1 = 80×64-bit table and `mode` honoured; 0 = 64×32-bit table only, `mode` ignored and treated as 0.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a sequence; sampled only in IDLE.
- `mode` in 1: 0 = SHA-224/256 (64 rounds), 1 = SHA-384/512 (80 rounds); latched at accepted `start`.
- `abort` in 1: terminate the current sequence.
- `k_ready` in 1: consumer accepts the current constant.
- `k` out 64: round constant. In SHA-256 mode, `k[63:32]` = 0.
- `round` out 7: index of the constant currently on `k`.
- `k_valid` out 1: `k`/`round` valid.
- `k_last` out 1: the current round is the final round of the mode.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse after the final round is accepted.

## Operation

- States: IDLE, RUN, DONE.
- IDLE:
  - `start`=1 and `abort`=0 → RUN.
  - Latch `mode_q` (0 if `MODE512_EN`=0), set `round`=0, load `k`=K(0).
- RUN:
  - `k_valid`=1.
  - Handshake (`k_valid`&`k_ready`) on a non-last round: `round`+1, `k` loaded with K(round+1).
  - No handshake: `k`, `round`, `k_last` hold stable.
  - Handshake with `k_last`=1 → DONE.
- DONE: `done`=1 and `k_valid`=0 for exactly one cycle, then → IDLE. `start` is ignored in DONE.
- `abort`=1 in any state → IDLE next cycle with `k_valid`=0 and no `done` pulse. `k`/`round` keep their last values.
- `abort` and `start` together in IDLE: `abort` wins and no sequence starts.
- `start` in RUN is ignored; the sequence and `mode_q` are unaffected.
- Last round: 63 when `mode_q`=0, 79 when `mode_q`=1. `k_last` = RUN & (`round` = last). `round` never exceeds 79 and never wraps.
- Constant selection:
  - `mode_q`=0: `k` = {32'h0, T[round][63:32]}.
  - `mode_q`=1: `k` = T[round].
  - When `MODE512_EN`=0, T stores only the 32-bit upper halves for rounds 0–63.
- `mode` changes after the accepted `start` have no effect.

## Timing

- Reset values: `k`=0, `round`=0, `k_valid`=0, `k_last`=0, `busy`=0, `done`=0; state = IDLE.
- Reset is asynchronous. Asserting `rst` mid-sequence forces the reset values immediately and leaves no partial state.
- All outputs are registered. There is no combinational path from any input to any output.
- `start` accepted at edge t → `k_valid`=1, `round`=0 after edge t.
- Handshake at edge n → next `k`/`round` after edge n. Throughput is one constant per cycle with `k_ready` held high.
- With `k_ready`=1 throughout:
  - SHA-256: `k_valid` high 64 cycles, `done` on cycle 65 after start.
  - SHA-512: `k_valid` high 80 cycles, `done` on cycle 81 after start.
  - Earliest next `start` is accepted on cycle 66 (SHA-256) or 82 (SHA-512).
- `busy` is high from the cycle after the accepted `start` through the DONE cycle inclusive.

## Test plan

- **Reset and idle:** assert `rst`, then `start`=1 with `mode`=0 and `k_ready`=1.
  - Next cycle: `k`=0x0000_0000_428a2f98, `round`=0, `k_valid`=1.
  - Round 63: `k`=0x0000_0000_c67178f2 with `k_last`=1.
  - `done` one cycle later; 64 handshakes total.
- **SHA-512 full run:** `mode`=1, `k_ready`=1.
  - Round 0: `k`=0x428a2f98d728ae22.
  - Round 1: `k`=0x7137449123ef65cd.
  - Round 79: `k`=0x6c44198c4a475817 with `k_last`=1.
  - `done` pulses once; 80 handshakes total.
- **Backpressure:** SHA-256 with `k_ready` toggling randomly and held 0 for 5 cycles at round 10.
  - `k`/`round` stay stable while stalled.
  - Still exactly 64 distinct handshakes, in order 0..63, matching the reference table.
- **Abort and restart:** `abort` at round 30 of SHA-512.
  - Next cycle: IDLE, `k_valid`=0, `busy`=0, no `done`.
  - A following `start` begins again at round 0.
  - Same-cycle `start`+`abort` in IDLE → remains IDLE.
- **Ignored inputs:** pulse `start` with `mode`=1 during a SHA-256 run and during the DONE cycle.
  - The run still ends at round 63 and `done` pulses once.
  - `busy` falls one cycle after DONE.
- **`MODE512_EN`=0 build:** `mode`=1 is treated as SHA-256: 64 rounds, `k[63:32]`=0.
- **Async reset:** assert `rst` mid-run between clock edges. All outputs return to their reset values before the next edge.

Source files
------------

// File: rtl/sha2_k_if.sv
// Handshake bundle between the hash control / round logic and the SHA-2 round-constant
// sequencer.
//
// Signals:
//   start, mode, abort  - sequence control from the hash control FSM
//   k_ready             - round logic accepts the presented constant
//   k, round            - registered constant and its round index
//   k_valid, k_last     - constant qualifier and final-round flag
//   busy, done          - sequencer activity and end-of-sequence pulse
//
// Modports:
//   master - drives control and k_ready (control FSM / round logic side)
//   slave  - the sequencer itself
interface sha2_k_if;
    logic        start;
    logic        mode;
    logic        abort;
    logic        k_ready;
    logic [63:0] k;
    logic [6:0]  round;
    logic        k_valid;
    logic        k_last;
    logic        busy;
    logic        done;

    modport master (
        output start, mode, abort, k_ready,
        input  k, round, k_valid, k_last, busy, done
    );

    modport slave (
        input  start, mode, abort, k_ready,
        output k, round, k_valid, k_last, busy, done
    );
endinterface

// File: rtl/sha2_k_sequencer.sv
// SHA-2 round-constant sequencer.
//
// Holds the 80-entry, 64-bit SHA-512 K table; SHA-256 constants are the upper halves of the
// first 64 entries. On an accepted start it walks rounds 0..63 (SHA-224/256) or 0..79
// (SHA-384/512) and presents one registered constant per round on a valid/ready handshake.
//
// Parameters:
//   MODE512_EN - 1: full 64-bit table, mode honoured; 0: SHA-256 only, mode treated as 0
//
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - sha2_k_if slave modport (start/mode/abort/k_ready in; k/round/k_valid/k_last/
//         busy/done out)
//
// Every output is a register or a decode of registers only, so there is no input-to-output
// combinational path.
module sha2_k_sequencer #(
    parameter bit MODE512_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    sha2_k_if.slave  bus
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [63:0] KTable [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    // In the SHA-256-only build only the upper halves of rounds 0..63 are reachable, so the
    // lower halves and entries 64..79 drop out of the table entirely.
    function automatic logic [63:0] k_lookup(input logic [6:0] idx, input logic wide);
        logic [63:0] ent;
        ent = '0;
        if (!MODE512_EN) begin
            ent = {32'h0, KTable[idx[5:0]][63:32]};
        end else if (idx < 7'd80) begin
            ent = wide ? KTable[idx] : {32'h0, KTable[idx][63:32]};
        end
        return ent;
    endfunction

    state_e      state_q, state_d;
    logic        mode_q, mode_d;
    logic [6:0]  round_q, round_d;
    logic [63:0] k_q, k_d;
    logic [6:0]  last_round;
    logic        at_last;

    assign last_round = mode_q ? 7'd79 : 7'd63;
    assign at_last    = (round_q == last_round);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mode_q  <= 1'b0;
            round_q <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            round_q <= round_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        round_d = round_q;
        k_d     = k_q;
        // abort overrides everything, including a same-cycle start; k/round keep their values
        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_d = StRun;
                        mode_d  = MODE512_EN & bus.mode;
                        round_d = '0;
                        k_d     = k_lookup(7'd0, mode_d);
                    end
                end
                StRun: begin
                    if (bus.k_ready) begin
                        if (at_last) begin
                            state_d = StDone;
                        end else begin
                            round_d = round_q + 7'd1;
                            k_d     = k_lookup(round_d, mode_q);
                        end
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign bus.k       = k_q;
    assign bus.round   = round_q;
    assign bus.k_valid = (state_q == StRun);
    assign bus.k_last  = (state_q == StRun) && at_last;
    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = (state_q == StDone);

endmodule

// File: tb/tb_sha2_k_sequencer.sv
module tb_sha2_k_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sha2_k_if bus ();
    sha2_k_if bus0 ();

    sha2_k_sequencer #(.MODE512_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sha2_k_sequencer #(.MODE512_EN(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    localparam logic [63:0] KREF [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    typedef struct packed {
        logic [6:0]  round;
        logic [63:0] k;
        logic        last;
    } exp_t;

    exp_t q[$];
    exp_t q0[$];
    exp_t e_m;
    exp_t e_m0;

    int checks    = 0;
    int failures  = 0;
    int hs_cnt    = 0;
    int hs_cnt0   = 0;
    int done_cnt  = 0;
    int done_cnt0 = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_seq(input bit wide, input bit use0);
        exp_t e;
        int n = wide ? 80 : 64;
        for (int i = 0; i < n; i++) begin
            e.round = 7'(i);
            e.k     = wide ? KREF[i] : {32'h0, KREF[i][63:32]};
            e.last  = (i == n - 1);
            if (use0) q0.push_back(e);
            else      q.push_back(e);
        end
    endtask

    task automatic wait_done(input bit use0, input int start_n, input int exp_n,
                             input string tag);
        int n = start_n;
        bit seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk);
            n++;
            seen = use0 ? (bus0.done === 1'b1) : (bus.done === 1'b1);
        end
        chk(tag, 64'(n), 64'(exp_n));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_k"},       bus.k,              64'h0);
        chk({tag, "_round"},   64'(bus.round),     64'h0);
        chk({tag, "_k_valid"}, 64'(bus.k_valid),   64'h0);
        chk({tag, "_k_last"},  64'(bus.k_last),    64'h0);
        chk({tag, "_busy"},    64'(bus.busy),      64'h0);
        chk({tag, "_done"},    64'(bus.done),      64'h0);
    endtask

    // Scoreboard: each handshake pops the next expected round/constant.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (bus.k_valid && bus.k_ready && !bus.abort) begin
                hs_cnt++;
                if (q.size() == 0) begin
                    chk("hs_unexpected", 64'(q.size()), 64'd1);
                end else begin
                    e_m = q.pop_front();
                    chk("hs_round", 64'(bus.round),  64'(e_m.round));
                    chk("hs_k",     bus.k,           e_m.k);
                    chk("hs_last",  64'(bus.k_last), 64'(e_m.last));
                end
            end
            if (bus.done) done_cnt++;
            if (bus0.k_valid && bus0.k_ready && !bus0.abort) begin
                hs_cnt0++;
                if (q0.size() == 0) begin
                    chk("hs0_unexpected", 64'(q0.size()), 64'd1);
                end else begin
                    e_m0 = q0.pop_front();
                    chk("hs0_round", 64'(bus0.round),  64'(e_m0.round));
                    chk("hs0_k",     bus0.k,           e_m0.k);
                    chk("hs0_last",  64'(bus0.k_last), 64'(e_m0.last));
                end
            end
            if (bus0.done) done_cnt0++;
        end
    end

    int  hs0;
    int  dc;
    int  n;
    bit  stall_seen;

    initial begin
        bus.start  = 1'b0;
        bus.mode   = 1'b0;
        bus.abort  = 1'b0;
        bus.k_ready = 1'b1;
        bus0.start = 1'b0;
        bus0.mode  = 1'b0;
        bus0.abort = 1'b0;
        bus0.k_ready = 1'b1;

        // Reset values
        @(negedge clk);
        chk_reset_vals("rst");
        cyc(1);
        rst = 1'b0;

        // SHA-256 full run
        push_seq(1'b0, 1'b0);
        hs0 = hs_cnt;
        dc  = done_cnt;
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        cyc(1);
        bus.start = 1'b0;
        @(negedge clk);
        chk("t1_valid", 64'(bus.k_valid), 64'd1);
        chk("t1_round", 64'(bus.round),   64'd0);
        chk("t1_k0",    bus.k,            64'h0000_0000_428a_2f98);
        chk("t1_busy",  64'(bus.busy),    64'd1);
        wait_done(1'b0, 1, 65, "t1_done_cycle");
        chk("t1_done_busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        chk("t1_done_fall", 64'(bus.done),     64'd0);
        chk("t1_busy_fall", 64'(bus.busy),     64'd0);
        chk("t1_done_once", 64'(done_cnt - dc), 64'd1);
        chk("t1_hs_count",  64'(hs_cnt - hs0),  64'd64);
        chk("t1_sb_empty",  64'(q.size()),      64'd0);

        // SHA-512 full run; mode changes after accept must not matter
        cyc(1);
        push_seq(1'b1, 1'b0);
        hs0 = hs_cnt;
        dc  = done_cnt;
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        @(negedge clk);
        chk("t2_k0", bus.k, 64'h428a2f98d728ae22);
        @(negedge clk);
        chk("t2_k1",     bus.k,           64'h7137449123ef65cd);
        chk("t2_round1", 64'(bus.round),  64'd1);
        wait_done(1'b0, 2, 81, "t2_done_cycle");
        @(negedge clk);
        chk("t2_busy_fall", 64'(bus.busy),     64'd0);
        chk("t2_done_once", 64'(done_cnt - dc), 64'd1);
        chk("t2_hs_count",  64'(hs_cnt - hs0),  64'd80);
        chk("t2_sb_empty",  64'(q.size()),      64'd0);

        // Backpressure on SHA-256
        cyc(1);
        push_seq(1'b0, 1'b0);
        hs0 = hs_cnt;
        dc  = done_cnt;
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        cyc(1);
        bus.start = 1'b0;
        stall_seen = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 1000) begin
            if (!stall_seen && bus.k_valid && bus.round == 7'd10) begin
                bus.k_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("t3_stall_round", 64'(bus.round),   64'd10);
                    chk("t3_stall_k",     bus.k,            {32'h0, KREF[10][63:32]});
                    chk("t3_stall_valid", 64'(bus.k_valid), 64'd1);
                    cyc(1);
                end
                stall_seen = 1'b1;
            end else begin
                bus.k_ready = 1'($urandom_range(0, 1));
                cyc(1);
            end
            n++;
        end
        bus.k_ready = 1'b1;
        chk("t3_stall_seen", 64'(stall_seen), 64'd1);
        chk("t3_done_seen",  64'(bus.done),   64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("t3_busy_fall", 64'(bus.busy),      64'd0);
        chk("t3_done_once", 64'(done_cnt - dc), 64'd1);
        chk("t3_hs_count",  64'(hs_cnt - hs0),  64'd64);
        chk("t3_sb_empty",  64'(q.size()),      64'd0);

        // Abort at round 30 of SHA-512
        cyc(1);
        push_seq(1'b1, 1'b0);
        hs0 = hs_cnt;
        dc  = done_cnt;
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        n = 0;
        while (bus.round != 7'd30 && n < 200) begin
            cyc(1);
            n++;
        end
        chk("t4_reach30", 64'(bus.round), 64'd30);
        bus.abort = 1'b1;
        cyc(1);
        bus.abort = 1'b0;
        @(negedge clk);
        chk("t4_valid", 64'(bus.k_valid),   64'd0);
        chk("t4_busy",  64'(bus.busy),      64'd0);
        chk("t4_done",  64'(bus.done),      64'd0);
        chk("t4_round_hold", 64'(bus.round), 64'd30);
        chk("t4_k_hold", bus.k,             KREF[30]);
        chk("t4_hs_count", 64'(hs_cnt - hs0), 64'd30);
        q.delete();
        @(negedge clk);
        @(negedge clk);
        chk("t4_no_done", 64'(done_cnt - dc), 64'd0);
        // Restart begins again at round 0
        cyc(1);
        push_seq(1'b0, 1'b0);
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        cyc(1);
        bus.start = 1'b0;
        @(negedge clk);
        chk("t4_rs_valid", 64'(bus.k_valid), 64'd1);
        chk("t4_rs_round", 64'(bus.round),   64'd0);
        chk("t4_rs_k0",    bus.k,            64'h0000_0000_428a_2f98);
        wait_done(1'b0, 1, 65, "t4_rs_done_cycle");
        @(negedge clk);
        chk("t4_rs_sb_empty", 64'(q.size()), 64'd0);
        // start and abort together in IDLE
        cyc(1);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        chk("t4_sa_valid", 64'(bus.k_valid), 64'd0);
        chk("t4_sa_busy",  64'(bus.busy),    64'd0);
        @(negedge clk);
        chk("t4_sa_valid2", 64'(bus.k_valid), 64'd0);

        // start ignored during RUN and during DONE
        cyc(1);
        push_seq(1'b0, 1'b0);
        hs0 = hs_cnt;
        dc  = done_cnt;
        bus.start = 1'b1;
        bus.mode  = 1'b0;
        cyc(1);
        bus.start = 1'b0;
        cyc(19);
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        cyc(44);
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        @(negedge clk);
        chk("t5_done", 64'(bus.done), 64'd1);
        chk("t5_busy", 64'(bus.busy), 64'd1);
        cyc(1);
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        @(negedge clk);
        chk("t5_done_fall", 64'(bus.done),    64'd0);
        chk("t5_busy_fall", 64'(bus.busy),    64'd0);
        chk("t5_valid",     64'(bus.k_valid), 64'd0);
        @(negedge clk);
        chk("t5_no_restart", 64'(bus.k_valid),  64'd0);
        chk("t5_done_once",  64'(done_cnt - dc), 64'd1);
        chk("t5_hs_count",   64'(hs_cnt - hs0),  64'd64);
        chk("t5_sb_empty",   64'(q.size()),      64'd0);

        // SHA-256-only build treats mode=1 as SHA-256
        cyc(1);
        push_seq(1'b0, 1'b1);
        hs0 = hs_cnt0;
        dc  = done_cnt0;
        bus0.start = 1'b1;
        bus0.mode  = 1'b1;
        cyc(1);
        bus0.start = 1'b0;
        @(negedge clk);
        chk("t6_k0",    bus0.k,           64'h0000_0000_428a_2f98);
        chk("t6_round", 64'(bus0.round),  64'd0);
        wait_done(1'b1, 1, 65, "t6_done_cycle");
        @(negedge clk);
        chk("t6_busy_fall", 64'(bus0.busy),       64'd0);
        chk("t6_done_once", 64'(done_cnt0 - dc),  64'd1);
        chk("t6_hs_count",  64'(hs_cnt0 - hs0),   64'd64);
        chk("t6_sb_empty",  64'(q0.size()),       64'd0);
        bus0.mode = 1'b0;

        // Asynchronous reset between clock edges
        cyc(1);
        push_seq(1'b1, 1'b0);
        bus.start = 1'b1;
        bus.mode  = 1'b1;
        cyc(1);
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        cyc(20);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_vals("t7");
        q.delete();
        cyc(2);
        rst = 1'b0;
        @(negedge clk);
        chk("t7_idle_valid", 64'(bus.k_valid), 64'd0);
        chk("t7_idle_busy",  64'(bus.busy),    64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
